bus_reg_bank: RTL and testbench

- Register bank directly downstream of the shared 24-bit processor bus in the matrix-multiplication core.
- Each cycle it captures the bus value into at most one architectural register, selected by a write-select code; it also performs single-register increments for address and loop counters.
- Its register outputs feed back as the source operands of the bus multiplexer, and it uses the same select encoding as the bus read side.

---
 rtl/bus_reg_bank_if.sv | 49 ++++
 rtl/bus_reg_bank.sv | 236 +++++++++++++++++++++++
 tb/tb_bus_reg_bank.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/bus_reg_bank_if.sv
// rtl/bus_reg_bank_if.sv - bus-side signal bundle for the processor-bus register bank
//
// Groups the bank's bus inputs and architectural register outputs.
//   busin    [BUS_W] bus value to capture
//   write_en [5]     write-select code, 0 = no write
//   inc_sel  [3]     increment select, 0 = none
//   pc, ir, ar       16-bit program counter / instruction / address registers
//   ac               24-bit accumulator
//   x, y, z          8-bit loop indices
//   stxy, styz, stxz 16-bit matrix stride/base registers
//   r, r1, r2, r3    general registers (16/8/24/16 bits)
//   dr               8-bit data register
//   wr_done          one-cycle pulse after a write took effect
// Modports: master drives the selects and bus value, slave is the bank.
interface bus_reg_bank_if #(
   parameter int BUS_W = 24
);
   logic [BUS_W-1:0] busin;
   logic [4:0]       write_en;
   logic [2:0]       inc_sel;
   logic [15:0]      pc;
   logic [15:0]      ir;
   logic [15:0]      ar;
   logic [23:0]      ac;
   logic [7:0]       x;
   logic [7:0]       y;
   logic [7:0]       z;
   logic [15:0]      stxy;
   logic [15:0]      styz;
   logic [15:0]      stxz;
   logic [15:0]      r;
   logic [7:0]       r1;
   logic [23:0]      r2;
   logic [15:0]      r3;
   logic [7:0]       dr;
   logic             wr_done;

   modport master (
      output busin, write_en, inc_sel,
      input  pc, ir, ar, ac, x, y, z, stxy, styz, stxz,
      input  r, r1, r2, r3, dr, wr_done
   );

   modport slave (
      input  busin, write_en, inc_sel,
      output pc, ir, ar, ac, x, y, z, stxy, styz, stxz,
      output r, r1, r2, r3, dr, wr_done
   );
endinterface

// File: rtl/bus_reg_bank.sv
// rtl/bus_reg_bank.sv - architectural register bank fed by the shared processor bus
//
// Each rising edge captures busin into at most one register chosen by
// write_en and applies at most one increment chosen by inc_sel. Outputs are
// straight register outputs and feed back to the bus read multiplexer.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (pc -> PC_RST, all else -> 0)
//   bus    bus_reg_bank_if.slave: busin/write_en/inc_sel in, registers and
//          wr_done out
// Optional build macro BUS_REG_BANK_ACCUM_EN: write code 18 accumulates
// busin into ac (modulo 2^24) and pulses wr_done.
module bus_reg_bank #(
   parameter int          BUS_W  = 24,
   parameter logic [15:0] PC_RST = 16'd0
) (
   input  logic           clk,
   input  logic           rst_n,
   bus_reg_bank_if.slave  bus
);

   // Write-select codes, shared with the bus read side. Codes 1 and 2 name
   // the instruction/data memories, which are sources only.
   localparam logic [4:0] WR_PC   = 5'd3;
   localparam logic [4:0] WR_IR   = 5'd4;
   localparam logic [4:0] WR_AR   = 5'd5;
   localparam logic [4:0] WR_AC   = 5'd6;
   localparam logic [4:0] WR_X    = 5'd7;
   localparam logic [4:0] WR_Y    = 5'd8;
   localparam logic [4:0] WR_Z    = 5'd9;
   localparam logic [4:0] WR_STXY = 5'd10;
   localparam logic [4:0] WR_STYZ = 5'd11;
   localparam logic [4:0] WR_STXZ = 5'd12;
   localparam logic [4:0] WR_R    = 5'd13;
   localparam logic [4:0] WR_R1   = 5'd14;
   localparam logic [4:0] WR_R2   = 5'd15;
   localparam logic [4:0] WR_R3   = 5'd16;
   localparam logic [4:0] WR_DR   = 5'd17;
`ifdef BUS_REG_BANK_ACCUM_EN
   localparam logic [4:0] WR_ACC  = 5'd18;
`endif

   localparam logic [2:0] INC_PC  = 3'd1;
   localparam logic [2:0] INC_AR  = 3'd2;
   localparam logic [2:0] INC_X   = 3'd3;
   localparam logic [2:0] INC_Y   = 3'd4;
   localparam logic [2:0] INC_Z   = 3'd5;
   localparam logic [2:0] CLR_XYZ = 3'd6;

   logic [BUS_W-1:0] busin_w;
   logic [23:0]      bus24;

   logic [15:0] pc_q,   pc_d;
   logic [15:0] ir_q,   ir_d;
   logic [15:0] ar_q,   ar_d;
   logic [23:0] ac_q,   ac_d;
   logic [7:0]  x_q,    x_d;
   logic [7:0]  y_q,    y_d;
   logic [7:0]  z_q,    z_d;
   logic [15:0] stxy_q, stxy_d;
   logic [15:0] styz_q, styz_d;
   logic [15:0] stxz_q, stxz_d;
   logic [15:0] r_q,    r_d;
   logic [7:0]  r1_q,   r1_d;
   logic [23:0] r2_q,   r2_d;
   logic [15:0] r3_q,   r3_d;
   logic [7:0]  dr_q,   dr_d;
   logic        wr_done_q, wr_done_d;

   // Registers are at most 24 bits wide; anything above is discarded.
   assign busin_w = bus.busin;
   assign bus24   = busin_w[23:0];

   // Next-state: the increment is applied first and the write second, so a
   // write to the same register overrides the increment, while a write to a
   // different register leaves the increment intact. The same ordering makes
   // "write x/y/z with clear-all" keep only the written index.
   always_comb begin
      pc_d      = pc_q;
      ir_d      = ir_q;
      ar_d      = ar_q;
      ac_d      = ac_q;
      x_d       = x_q;
      y_d       = y_q;
      z_d       = z_q;
      stxy_d    = stxy_q;
      styz_d    = styz_q;
      stxz_d    = stxz_q;
      r_d       = r_q;
      r1_d      = r1_q;
      r2_d      = r2_q;
      r3_d      = r3_q;
      dr_d      = dr_q;
      wr_done_d = 1'b0;

      case (bus.inc_sel)
         INC_PC:  pc_d = pc_q + 16'd1;
         INC_AR:  ar_d = ar_q + 16'd1;
         INC_X:   x_d  = x_q + 8'd1;
         INC_Y:   y_d  = y_q + 8'd1;
         INC_Z:   z_d  = z_q + 8'd1;
         CLR_XYZ: begin
            x_d = 8'd0;
            y_d = 8'd0;
            z_d = 8'd0;
         end
         default: ;
      endcase

      case (bus.write_en)
         WR_PC: begin
            pc_d      = bus24[15:0];
            wr_done_d = 1'b1;
         end
         WR_IR: begin
            ir_d      = bus24[15:0];
            wr_done_d = 1'b1;
         end
         WR_AR: begin
            ar_d      = bus24[15:0];
            wr_done_d = 1'b1;
         end
         WR_AC: begin
            ac_d      = bus24;
            wr_done_d = 1'b1;
         end
         WR_X: begin
            x_d       = bus24[7:0];
            wr_done_d = 1'b1;
         end
         WR_Y: begin
            y_d       = bus24[7:0];
            wr_done_d = 1'b1;
         end
         WR_Z: begin
            z_d       = bus24[7:0];
            wr_done_d = 1'b1;
         end
         WR_STXY: begin
            stxy_d    = bus24[15:0];
            wr_done_d = 1'b1;
         end
         WR_STYZ: begin
            styz_d    = bus24[15:0];
            wr_done_d = 1'b1;
         end
         WR_STXZ: begin
            stxz_d    = bus24[15:0];
            wr_done_d = 1'b1;
         end
         WR_R: begin
            r_d       = bus24[15:0];
            wr_done_d = 1'b1;
         end
         WR_R1: begin
            r1_d      = bus24[7:0];
            wr_done_d = 1'b1;
         end
         WR_R2: begin
            r2_d      = bus24;
            wr_done_d = 1'b1;
         end
         WR_R3: begin
            r3_d      = bus24[15:0];
            wr_done_d = 1'b1;
         end
         WR_DR: begin
            dr_d      = bus24[7:0];
            wr_done_d = 1'b1;
         end
`ifdef BUS_REG_BANK_ACCUM_EN
         // Uses the pre-edge ac, so ac->bus->ac feedback is hazard-free.
         WR_ACC: begin
            ac_d      = ac_q + bus24;
            wr_done_d = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q      <= PC_RST;
         ir_q      <= 16'd0;
         ar_q      <= 16'd0;
         ac_q      <= 24'd0;
         x_q       <= 8'd0;
         y_q       <= 8'd0;
         z_q       <= 8'd0;
         stxy_q    <= 16'd0;
         styz_q    <= 16'd0;
         stxz_q    <= 16'd0;
         r_q       <= 16'd0;
         r1_q      <= 8'd0;
         r2_q      <= 24'd0;
         r3_q      <= 16'd0;
         dr_q      <= 8'd0;
         wr_done_q <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         ar_q      <= ar_d;
         ac_q      <= ac_d;
         x_q       <= x_d;
         y_q       <= y_d;
         z_q       <= z_d;
         stxy_q    <= stxy_d;
         styz_q    <= styz_d;
         stxz_q    <= stxz_d;
         r_q       <= r_d;
         r1_q      <= r1_d;
         r2_q      <= r2_d;
         r3_q      <= r3_d;
         dr_q      <= dr_d;
         wr_done_q <= wr_done_d;
      end
   end

   assign bus.pc      = pc_q;
   assign bus.ir      = ir_q;
   assign bus.ar      = ar_q;
   assign bus.ac      = ac_q;
   assign bus.x       = x_q;
   assign bus.y       = y_q;
   assign bus.z       = z_q;
   assign bus.stxy    = stxy_q;
   assign bus.styz    = styz_q;
   assign bus.stxz    = stxz_q;
   assign bus.r       = r_q;
   assign bus.r1      = r1_q;
   assign bus.r2      = r2_q;
   assign bus.r3      = r3_q;
   assign bus.dr      = dr_q;
   assign bus.wr_done = wr_done_q;

endmodule

// File: tb/tb_bus_reg_bank.sv
// tb/tb_bus_reg_bank.sv - directed self-checking bench for bus_reg_bank
module tb_bus_reg_bank;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   bus_reg_bank_if #(.BUS_W(24)) bus ();

   bus_reg_bank #(.BUS_W(24), .PC_RST(16'd0)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one edge and land 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] we, input logic [2:0] inc, input logic [23:0] val);
      bus.write_en = we;
      bus.inc_sel  = inc;
      bus.busin    = val;
   endtask

   logic [4:0]  unused_codes [5];
   logic [4:0]  wr_codes     [8];
   logic [23:0] wr_vals      [8];

   initial begin
      n_tests = 0;
      n_fail  = 0;
      unused_codes = '{5'd0, 5'd1, 5'd2, 5'd20, 5'd31};
      wr_codes     = '{5'd4, 5'd10, 5'd11, 5'd12, 5'd14, 5'd15, 5'd16, 5'd17};
      wr_vals      = '{24'h11A1B1, 24'h22A2B2, 24'h33A3B3, 24'h44A4B4,
                       24'h55A5B5, 24'h66A6B6, 24'h77A7B7, 24'h88A8B8};

      rst_n = 1'b0;
      drive(5'd0, 3'd0, 24'd0);
      #2;
      check("rst_pc", 32'(bus.pc), 32'h0);
      check("rst_wr_done", 32'(bus.wr_done), 32'h0);
      tick();
      rst_n = 1'b1;

      // Load pc, then assert reset mid-cycle and check before the next edge.
      drive(5'd3, 3'd0, 24'h001234);
      tick();
      check("pc_load", 32'(bus.pc), 32'h1234);
      check("pc_load_done", 32'(bus.wr_done), 32'h1);
      drive(5'd7, 3'd0, 24'h0000AA);
      tick();
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst_pc", 32'(bus.pc), 32'h0);
      check("async_rst_x", 32'(bus.x), 32'h0);
      check("async_rst_done", 32'(bus.wr_done), 32'h0);
      #1;
      rst_n = 1'b1;
      drive(5'd0, 3'd0, 24'd0);
      tick();

      // Truncation and wr_done pulse.
      drive(5'd7, 3'd0, 24'hABCDEF);
      tick();
      check("trunc_x", 32'(bus.x), 32'hEF);
      check("trunc_done", 32'(bus.wr_done), 32'h1);
      drive(5'd6, 3'd0, 24'hABCDEF);
      tick();
      check("ac_full", 32'(bus.ac), 32'hABCDEF);
      drive(5'd0, 3'd0, 24'hABCDEF);
      tick();
      check("done_clear", 32'(bus.wr_done), 32'h0);
      check("x_hold", 32'(bus.x), 32'hEF);

      // Same-register conflict: write wins.
      drive(5'd3, 3'd0, 24'h000010);
      tick();
      drive(5'd3, 3'd1, 24'h000200);
      tick();
      check("pc_write_wins", 32'(bus.pc), 32'h0200);
      drive(5'd0, 3'd1, 24'h0);
      tick();
      check("pc_inc", 32'(bus.pc), 32'h0201);

      // Wrap and independent write/increment.
      drive(5'd7, 3'd0, 24'h0000FF);
      tick();
      drive(5'd5, 3'd0, 24'h00FFFF);
      tick();
      check("x_ff", 32'(bus.x), 32'hFF);
      check("ar_ffff", 32'(bus.ar), 32'hFFFF);
      drive(5'd0, 3'd3, 24'h0);
      tick();
      check("x_wrap", 32'(bus.x), 32'h0);
      drive(5'd13, 3'd2, 24'h000005);
      tick();
      check("ar_wrap", 32'(bus.ar), 32'h0);
      check("r_indep", 32'(bus.r), 32'h5);

      // Unused codes change nothing.
      for (int i = 0; i < 5; i++) begin
         drive(unused_codes[i], 3'd0, 24'hFFFFFF);
         tick();
         check($sformatf("unused_%0d_pc", unused_codes[i]), 32'(bus.pc), 32'h0201);
         check($sformatf("unused_%0d_ac", unused_codes[i]), 32'(bus.ac), 32'hABCDEF);
         check($sformatf("unused_%0d_r", unused_codes[i]), 32'(bus.r), 32'h5);
         check($sformatf("unused_%0d_done", unused_codes[i]), 32'(bus.wr_done), 32'h0);
      end

      // Clear-all of loop indices.
      drive(5'd7, 3'd0, 24'd3);
      tick();
      drive(5'd8, 3'd0, 24'd4);
      tick();
      drive(5'd9, 3'd0, 24'd5);
      tick();
      check("xyz_load", {8'h0, bus.x, bus.y, bus.z}, 32'h030405);
      drive(5'd0, 3'd6, 24'd0);
      tick();
      check("xyz_clear", {8'h0, bus.x, bus.y, bus.z}, 32'h0);

      // Write y while clearing: y keeps the bus value, x and z clear.
      drive(5'd7, 3'd0, 24'd3);
      tick();
      drive(5'd9, 3'd0, 24'd5);
      tick();
      drive(5'd8, 3'd6, 24'h000044);
      tick();
      check("y_write_clr", {8'h0, bus.x, bus.y, bus.z}, 32'h004400);

      // Remaining registers with width truncation.
      for (int i = 0; i < 8; i++) begin
         drive(wr_codes[i], 3'd0, wr_vals[i]);
         tick();
         check($sformatf("wr_%0d_done", wr_codes[i]), 32'(bus.wr_done), 32'h1);
      end
      drive(5'd0, 3'd0, 24'd0);
      tick();
      check("ir",   32'(bus.ir),   32'hA1B1);
      check("stxy", 32'(bus.stxy), 32'hA2B2);
      check("styz", 32'(bus.styz), 32'hA3B3);
      check("stxz", 32'(bus.stxz), 32'hA4B4);
      check("r1",   32'(bus.r1),   32'hB5);
      check("r2",   32'(bus.r2),   32'h66A6B6);
      check("r3",   32'(bus.r3),   32'hA7B7);
      check("dr",   32'(bus.dr),   32'hB8);

      // pc wrap.
      drive(5'd3, 3'd0, 24'h12FFFF);
      tick();
      drive(5'd0, 3'd1, 24'd0);
      tick();
      check("pc_wrap", 32'(bus.pc), 32'h0);

      // Accumulate code 18.
      drive(5'd6, 3'd0, 24'hFFFFF0);
      tick();
      drive(5'd18, 3'd0, 24'h000020);
      tick();
`ifdef BUS_REG_BANK_ACCUM_EN
      check("accum_ac", 32'(bus.ac), 32'h000010);
      check("accum_done", 32'(bus.wr_done), 32'h1);
`else
      check("accum_ac", 32'(bus.ac), 32'hFFFFF0);
      check("accum_done", 32'(bus.wr_done), 32'h0);
`endif

      drive(5'd0, 3'd0, 24'd0);
      tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
